// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one memory port between fetch (0), mmr (1) and stack (2).
// Latches the winner's request, issues one memory cycle and returns read data after RD_LAT.
module mem_bus_arbiter #(
  parameter int AW     = 12,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    req_i,
  input  logic [2:0]    we_i,
  input  logic [AW-1:0] fetch_addr,
  input  logic [AW-1:0] mmr_addr,
  input  logic [AW-1:0] stack_addr,
  input  logic [DW-1:0] mmr_wdata,
  input  logic [DW-1:0] stack_wdata,
  output logic [2:0]    gnt_o,
  output logic [2:0]    rvalid_o,
  output logic [DW-1:0] rdata_o,
  output logic          mem_en,
  output logic          mem_we,
  output logic [1:0]    mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy_o
);

  generate
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
      $error("mem_bus_arbiter: RD_LAT must be in 1..3");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state, state_nx;
  logic [1:0]    ptr, ptr_nx;
  logic [1:0]    owner, owner_nx;
  logic [1:0]    cnt, cnt_nx;
  logic [AW-1:0] addr_q, addr_nx;
  logic [DW-1:0] wdata_q, wdata_nx;
  logic          we_q, we_nx;
  logic [2:0]    rvalid_nx;
  logic [DW-1:0] rdata_nx;

  logic [3:0]    req_pad;
  logic [1:0]    cand1, cand2, win;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Priority scan ptr+1, ptr+2, then ptr itself; only used when some req is set.
  always_comb begin
    req_pad = {1'b0, req_i};
    cand1   = inc3(ptr);
    cand2   = inc3(cand1);
    if (req_pad[cand1])      win = cand1;
    else if (req_pad[cand2]) win = cand2;
    else                     win = ptr;
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    owner_nx  = owner;
    cnt_nx    = cnt;
    addr_nx   = addr_q;
    wdata_nx  = wdata_q;
    we_nx     = we_q;
    rvalid_nx = '0;
    rdata_nx  = rdata_o;
    unique case (state)
      IDLE: begin
        if (req_i != 3'b000) begin
          owner_nx = win;
          ptr_nx   = win;
          state_nx = ISSUE;
          unique case (win)
            2'd1: begin
              addr_nx  = mmr_addr;
              wdata_nx = mmr_wdata;
              we_nx    = we_i[1];
            end
            2'd2: begin
              addr_nx  = stack_addr;
              wdata_nx = stack_wdata;
              we_nx    = we_i[2];
            end
            default: begin
              addr_nx  = fetch_addr;
              wdata_nx = '0;
              we_nx    = 1'b0;
            end
          endcase
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_nx = IDLE;
        end else begin
          cnt_nx   = 2'(RD_LAT - 1);
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt != 2'd0) begin
          cnt_nx = cnt - 2'd1;
        end else begin
          rdata_nx  = mem_rdata;
          rvalid_nx = 3'b001 << owner;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd2;
      owner    <= 2'd0;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rvalid_o <= '0;
      rdata_o  <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      owner    <= owner_nx;
      cnt      <= cnt_nx;
      addr_q   <= addr_nx;
      wdata_q  <= wdata_nx;
      we_q     <= we_nx;
      rvalid_o <= rvalid_nx;
      rdata_o  <= rdata_nx;
    end
  end

  // Memory-side outputs decode from registered state so reset clears them at once.
  always_comb begin
    gnt_o     = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 2'd3;
    mem_addr  = '0;
    mem_wdata = '0;
    busy_o    = (state == ISSUE) || (state == WAIT);
    if (state == ISSUE) begin
      gnt_o     = 3'b001 << owner;
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_sel   = owner;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance at RD_LAT=1, one at RD_LAT=3,
// sharing the requester inputs.
module tb_mem_bus_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    req_i, we_i;
  logic [AW-1:0] fetch_addr, mmr_addr, stack_addr;
  logic [DW-1:0] mmr_wdata, stack_wdata;
  logic [DW-1:0] mrd1, mrd3;

  logic [2:0]    gnt1, rv1, gnt3, rv3;
  logic [DW-1:0] rdata1, rdata3, wdata1, wdata3;
  logic          en1, we1, busy1, en3, we3, busy3;
  logic [1:0]    sel1, sel3;
  logic [AW-1:0] addr1, addr3;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i),
    .fetch_addr(fetch_addr), .mmr_addr(mmr_addr), .stack_addr(stack_addr),
    .mmr_wdata(mmr_wdata), .stack_wdata(stack_wdata),
    .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rdata1),
    .mem_en(en1), .mem_we(we1), .mem_sel(sel1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_rdata(mrd1), .busy_o(busy1)
  );

  mem_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i),
    .fetch_addr(fetch_addr), .mmr_addr(mmr_addr), .stack_addr(stack_addr),
    .mmr_wdata(mmr_wdata), .stack_wdata(stack_wdata),
    .gnt_o(gnt3), .rvalid_o(rv3), .rdata_o(rdata3),
    .mem_en(en3), .mem_we(we3), .mem_sel(sel3), .mem_addr(addr3),
    .mem_wdata(wdata3), .mem_rdata(mrd3), .busy_o(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [2:0] exp_g;

  initial begin
    rst_n = 1'b1; req_i = '0; we_i = '0;
    fetch_addr = '0; mmr_addr = '0; stack_addr = '0;
    mmr_wdata = '0; stack_wdata = '0; mrd1 = '0; mrd3 = '0;
    #2;
    do_reset();

    chk("rst_sel", 32'(sel1), 32'd3);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_gnt", 32'(gnt1), 32'd0);

    // Single fetch read, RD_LAT=1
    req_i = 3'b001; fetch_addr = 12'h123;
    tick();
    chk("rd_gnt", 32'(gnt1), 32'h1);
    chk("rd_sel", 32'(sel1), 32'd0);
    chk("rd_addr", 32'(addr1), 32'h123);
    chk("rd_en", 32'(en1), 32'd1);
    chk("rd_we", 32'(we1), 32'd0);
    req_i = 3'b000;
    tick();
    chk("rd_wait_en", 32'(en1), 32'd0);
    chk("rd_wait_sel", 32'(sel1), 32'd3);
    chk("rd_wait_busy", 32'(busy1), 32'd1);
    mrd1 = 16'hBEEF;
    tick();
    chk("rd_rvalid", 32'(rv1), 32'h1);
    chk("rd_rdata", 32'(rdata1), 32'hBEEF);
    chk("rd_idle_busy", 32'(busy1), 32'd0);
    tick();
    chk("rd_rvalid_pulse", 32'(rv1), 32'h0);
    chk("rd_rdata_hold", 32'(rdata1), 32'hBEEF);

    // Reset asserted in the middle of WAIT
    req_i = 3'b001; fetch_addr = 12'h0F0; mrd1 = 16'h1111;
    tick();
    req_i = 3'b000;
    tick();
    chk("mr_in_wait", 32'(busy1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_gnt", 32'(gnt1), 32'd0);
    chk("mr_rvalid", 32'(rv1), 32'd0);
    chk("mr_rdata", 32'(rdata1), 32'd0);
    chk("mr_en", 32'(en1), 32'd0);
    chk("mr_we", 32'(we1), 32'd0);
    chk("mr_addr", 32'(addr1), 32'd0);
    chk("mr_wdata", 32'(wdata1), 32'd0);
    chk("mr_busy", 32'(busy1), 32'd0);
    chk("mr_sel", 32'(sel1), 32'd3);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_no_stale_rv", 32'(rv1), 32'd0);
    chk("mr_idle", 32'(busy1), 32'd0);
    tick();
    chk("mr_no_stale_rv2", 32'(rv1), 32'd0);

    // Stack write
    req_i = 3'b100; we_i = 3'b100; stack_addr = 12'hFFF; stack_wdata = 16'h5A5A;
    tick();
    chk("wr_gnt", 32'(gnt1), 32'h4);
    chk("wr_en", 32'(en1), 32'd1);
    chk("wr_we", 32'(we1), 32'd1);
    chk("wr_sel", 32'(sel1), 32'd2);
    chk("wr_addr", 32'(addr1), 32'hFFF);
    chk("wr_wdata", 32'(wdata1), 32'h5A5A);
    req_i = 3'b000; we_i = 3'b000;
    tick();
    chk("wr_idle", 32'(busy1), 32'd0);
    chk("wr_en_off", 32'(en1), 32'd0);
    chk("wr_no_rv", 32'(rv1), 32'd0);
    tick();
    chk("wr_no_rv2", 32'(rv1), 32'd0);

    // All three requesting: round-robin 0,1,2,0,1,2 (ptr back at 2 after the write)
    req_i = 3'b111; fetch_addr = 12'h010; mmr_addr = 12'h020; stack_addr = 12'h030;
    for (int k = 0; k < 6; k++) begin
      exp_g = 3'b001 << (k % 3);
      tick();
      chk("rr_gnt", 32'(gnt1), 32'(exp_g));
      chk("rr_addr", 32'(addr1), 32'(12'h010 * ((k % 3) + 1)));
      tick();
      mrd1 = 16'hA000 + 16'(k);
      tick();
      chk("rr_rvalid", 32'(rv1), 32'(exp_g));
      chk("rr_rdata", 32'(rdata1), 32'hA000 + 32'(k));
    end
    req_i = 3'b000;
    tick();
    chk("rr_stop", 32'(gnt1), 32'd0);

    // Fetch with we_i[0]=1 is still a read (ptr=2, so fetch wins)
    req_i = 3'b001; we_i = 3'b001; fetch_addr = 12'h456; mrd1 = 16'h1357;
    tick();
    chk("fw_gnt", 32'(gnt1), 32'h1);
    chk("fw_we", 32'(we1), 32'd0);
    req_i = 3'b000; we_i = 3'b000;
    tick();
    tick();
    chk("fw_rvalid", 32'(rv1), 32'h1);
    chk("fw_rdata", 32'(rdata1), 32'h1357);

    // RD_LAT=3: mmr read, fetch request arrives during WAIT
    do_reset();
    req_i = 3'b010; mmr_addr = 12'h0AA; mrd3 = 16'hDEAD;
    tick();
    chk("l3_gnt_mmr", 32'(gnt3), 32'h2);
    chk("l3_sel", 32'(sel3), 32'd1);
    req_i = 3'b001; fetch_addr = 12'h321;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("l3_wait_nognt", 32'(gnt3), 32'd0);
      chk("l3_wait_busy", 32'(busy3), 32'd1);
      chk("l3_wait_norv", 32'(rv3), 32'd0);
      if (c == 4) mrd3 = 16'hCAFE;
    end
    tick();
    mrd3 = 16'hDEAD;
    chk("l3_rvalid", 32'(rv3), 32'h2);
    chk("l3_rdata", 32'(rdata3), 32'hCAFE);
    chk("l3_rv_idle", 32'(busy3), 32'd0);
    chk("l3_rv_nognt", 32'(gnt3), 32'd0);
    tick();
    chk("l3_fetch_gnt", 32'(gnt3), 32'h1);
    chk("l3_fetch_addr", 32'(addr3), 32'h321);
    req_i = 3'b000;
    tick();
    tick();
    tick();
    mrd3 = 16'h2468;
    tick();
    chk("l3_fetch_rv", 32'(rv3), 32'h1);
    chk("l3_fetch_rdata", 32'(rdata3), 32'h2468);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
